sat_filter_arb: RTL and testbench

//   Shares one saturation filter (1-cycle latency, no backpressure) between NUM_REQ requesters.

---
 rtl/sat_filter_arb_if.sv | 32 +++
 rtl/sat_filter_arb.sv | 144 ++++++++++++++
 tb/tb_sat_filter_arb.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sat_filter_arb_if.sv
// ============================================================================
// Module   : sat_filter_arb_if
// Brief    : Requester-side request/response bus of the shared saturation filter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sat_filter_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_ovf;

  // Requesters drive samples and observe grants/results.
  modport master (
    output req_valid, req_data,
    input  req_ready, rsp_valid, rsp_data, rsp_ovf
  );

  // The arbiter consumes samples and returns grants/results.
  modport slave (
    input  req_valid, req_data,
    output req_ready, rsp_valid, rsp_data, rsp_ovf
  );
endinterface

`default_nettype wire

// File: rtl/sat_filter_arb.sv
// ============================================================================
// Module   : sat_filter_arb
// Brief    : Round-robin front end sharing one 1-cycle saturation filter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sat_filter_arb #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int CNT_W   = 8
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     en,
  output logic                          busy,
  sat_filter_arb_if.slave               bus,
  output logic                          flt_in_valid,
  output logic [DATA_W-1:0]             flt_in_data,
  input  wire logic                     flt_out_valid,
  input  wire logic [DATA_W-1:0]        flt_out_data,
  input  wire logic                     flt_ovf,
  output logic [NUM_REQ*CNT_W-1:0]      ovf_cnt,
  input  wire logic                     ovf_cnt_clr
);

  localparam int c_ptr_w = $clog2(NUM_REQ);
  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_run   = 2'd1;
  localparam logic [1:0] c_drain = 2'd2;
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [c_ptr_w-1:0]  r_rr_ptr;
  logic                r_flt_in_valid;
  logic [DATA_W-1:0]   r_flt_in_data;
  logic [c_ptr_w-1:0]  r_tag1;
  logic [c_ptr_w-1:0]  r_tag2;
  logic                r_tag2_vld;

  logic [c_ptr_w:0]    w_idx;
  logic [c_ptr_w-1:0]  w_win;
  logic [c_ptr_w-1:0]  w_next_ptr;
  logic                w_found;
  logic [NUM_REQ-1:0]  w_grant;
  logic [NUM_REQ-1:0]  w_rsp_valid;
  logic                w_issue;
  logic                w_xfer;
  logic                w_drained;

  // Rotating priority search: first valid requester at or after r_rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (c_ptr_w+1)'(k);
      if (w_idx >= (c_ptr_w+1)'(NUM_REQ)) begin
        w_idx = w_idx - (c_ptr_w+1)'(NUM_REQ);
      end
      if (!w_found && bus.req_valid[w_idx[c_ptr_w-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[c_ptr_w-1:0];
      end
    end
    w_grant[w_win] = w_found;
  end

  assign w_issue    = (r_state == c_run) && en;
  assign w_xfer     = w_issue && w_found;
  assign w_next_ptr = (w_win == c_ptr_w'(NUM_REQ-1)) ? '0 : w_win + c_ptr_w'(1);
  assign w_drained  = !r_flt_in_valid && !r_tag2_vld;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:  if (en) w_state_nxt = c_run;
      c_run:   if (!en) w_state_nxt = c_drain;
      c_drain: if (w_drained) w_state_nxt = en ? c_run : c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= c_idle;
      r_rr_ptr       <= '0;
      r_flt_in_valid <= 1'b0;
      r_flt_in_data  <= '0;
      r_tag1         <= '0;
      r_tag2         <= '0;
      r_tag2_vld     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_flt_in_valid <= w_xfer;
      r_flt_in_data  <= w_xfer ? bus.req_data[w_win*DATA_W +: DATA_W] : '0;
      r_tag2         <= r_tag1;
      r_tag2_vld     <= r_flt_in_valid;
      if (w_xfer) begin
        r_tag1   <= w_win;
        r_rr_ptr <= w_next_ptr;
      end
    end
  end

  // Result routing follows the tag that travelled alongside the sample.
  always_comb begin
    w_rsp_valid         = '0;
    w_rsp_valid[r_tag2] = flt_out_valid;
  end

  assign bus.req_ready = w_issue ? w_grant : '0;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_data  = flt_out_data;
  assign bus.rsp_ovf   = flt_ovf;
  assign flt_in_valid  = r_flt_in_valid;
  assign flt_in_data   = r_flt_in_data;
  assign busy          = (r_state != c_idle);

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;
    logic             w_hit;

    assign w_hit = flt_out_valid && flt_ovf && (r_tag2 == c_ptr_w'(g));

    // Clear has priority; the count sticks at its maximum instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (ovf_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_hit && (r_cnt != c_cnt_max)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign ovf_cnt[g*CNT_W +: CNT_W] = r_cnt;
  end

endmodule

`default_nettype wire

// File: tb/tb_sat_filter_arb.sv
// ============================================================================
// Module   : tb_sat_filter_arb
// Brief    : Self-checking bench: vector table, scoreboard and corner sequences.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sat_filter_arb;
  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 4;
  localparam int CNT_W     = 2;
  localparam int THRESHOLD = 8;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        busy;
  logic        flt_in_valid;
  logic [3:0]  flt_in_data;
  logic        flt_out_valid;
  logic [3:0]  flt_out_data;
  logic        flt_ovf;
  logic [7:0]  ovf_cnt;
  logic        ovf_cnt_clr;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int         idx;
    logic [3:0] data;
    logic       ovf;
    int         due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] data;
    logic [3:0]  ready;
  } vec_t;
  vec_t tbl[12];

  int exp4[5] = '{1, 2, 3, 3, 3};
  int exp5[4] = '{1, 1, 1, 0};

  sat_filter_arb_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  sat_filter_arb #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .busy          (busy),
    .bus           (bus),
    .flt_in_valid  (flt_in_valid),
    .flt_in_data   (flt_in_data),
    .flt_out_valid (flt_out_valid),
    .flt_out_data  (flt_out_data),
    .flt_ovf       (flt_ovf),
    .ovf_cnt       (ovf_cnt),
    .ovf_cnt_clr   (ovf_cnt_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] sat(input logic [3:0] v);
    return (v > 4'(THRESHOLD)) ? 4'(THRESHOLD) : v;
  endfunction

  // Behavioural saturation filter: one cycle latency, reset together with the arbiter.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_out_valid <= 1'b0;
      flt_out_data  <= 4'd0;
      flt_ovf       <= 1'b0;
    end else begin
      flt_out_valid <= flt_in_valid;
      flt_out_data  <= sat(flt_in_data);
      flt_ovf       <= flt_in_valid && (flt_in_data > 4'(THRESHOLD));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        mon_e = sb.pop_front();
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(4'b0001 << mon_e.idx));
        chk("rsp_data", 32'(bus.rsp_data), 32'(mon_e.data));
        chk("rsp_ovf", 32'(bus.rsp_ovf), 32'(mon_e.ovf));
      end else if (bus.rsp_valid != 4'd0) begin
        chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
      end
    end
  end

  task automatic drive_cycle(input logic e, input logic [3:0] v, input logic [15:0] d,
                             input logic [3:0] r);
    exp_t x;
    @(posedge clk);
    #1;
    en            = e;
    bus.req_valid = v;
    bus.req_data  = d;
    @(negedge clk);
    chk("req_ready", 32'(bus.req_ready), 32'(r));
    for (int i = 0; i < 4; i++) begin
      if (r[i]) begin
        x.idx  = i;
        x.data = sat(d[i*4 +: 4]);
        x.ovf  = d[i*4 +: 4] > 4'(THRESHOLD);
        x.due  = cyc + 2;
        sb.push_back(x);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(en, 4'd0, 16'd0, 4'd0);
  endtask

  task automatic clr_pulse();
    @(posedge clk);
    #1;
    bus.req_valid = 4'd0;
    ovf_cnt_clr   = 1'b1;
    @(posedge clk);
    #1;
    ovf_cnt_clr   = 1'b0;
    @(negedge clk);
    chk("ovf_cnt_after_clr", 32'(ovf_cnt), 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    en            = 1'b0;
    ovf_cnt_clr   = 1'b0;
    bus.req_valid = 4'd0;
    bus.req_data  = 16'd0;

    // {valid, data, expected grant}; rr pointer starts at 3 after the first sequence.
    tbl[0]  = '{4'b1000, 16'h7000, 4'b1000};
    tbl[1]  = '{4'b1111, 16'h4321, 4'b0001};
    tbl[2]  = '{4'b1111, 16'h4321, 4'b0010};
    tbl[3]  = '{4'b1111, 16'h4321, 4'b0100};
    tbl[4]  = '{4'b1111, 16'h4321, 4'b1000};
    tbl[5]  = '{4'b1111, 16'hFEDC, 4'b0001};
    tbl[6]  = '{4'b0001, 16'h0009, 4'b0001};
    tbl[7]  = '{4'b1001, 16'hA006, 4'b1000};
    tbl[8]  = '{4'b0000, 16'h0000, 4'b0000};
    tbl[9]  = '{4'b0110, 16'h0F80, 4'b0010};
    tbl[10] = '{4'b0110, 16'h0F80, 4'b0100};
    tbl[11] = '{4'b0011, 16'h00B0, 4'b0001};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flt_in_valid", 32'(flt_in_valid), 32'd0);
    chk("rst_flt_in_data", 32'(flt_in_data), 32'd0);
    chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single requester 2, data below threshold.
    drive_cycle(1'b1, 4'b0000, 16'h0000, 4'b0000);
    drive_cycle(1'b1, 4'b0100, 16'h0500, 4'b0100);
    drive_cycle(1'b1, 4'b0000, 16'h0000, 4'b0000);
    chk("t1_flt_in_valid", 32'(flt_in_valid), 32'd1);
    chk("t1_flt_in_data", 32'(flt_in_data), 32'd5);

    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b1, tbl[i].valid, tbl[i].data, tbl[i].ready);
    end
    idle(3);
    chk("tbl_ovf_cnt", 32'(ovf_cnt), 32'h52);

    // Requester 1 overflows three times, clear, then once more.
    repeat (3) drive_cycle(1'b1, 4'b0010, 16'h00C0, 4'b0010);
    idle(3);
    chk("t3_ovf_cnt1_x3", 32'(ovf_cnt[3:2]), 32'd3);
    clr_pulse();
    drive_cycle(1'b1, 4'b0010, 16'h00C0, 4'b0010);
    idle(3);
    chk("t3_ovf_cnt_x1", 32'(ovf_cnt), 32'h04);

    // Two-bit counter saturation, then clear colliding with an increment.
    clr_pulse();
    for (int k = 0; k < 5; k++) begin
      drive_cycle(1'b1, 4'b0001, 16'h000D, 4'b0001);
      idle(3);
      chk("t4_ovf_cnt0_sat", 32'(ovf_cnt[1:0]), 32'(exp4[k]));
    end
    drive_cycle(1'b1, 4'b0001, 16'h000D, 4'b0001);
    drive_cycle(1'b1, 4'b0000, 16'h0000, 4'b0000);
    @(posedge clk);
    #1;
    ovf_cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_cnt_clr = 1'b0;
    @(negedge clk);
    chk("t4_clr_beats_inc", 32'(ovf_cnt), 32'd0);

    // Enable drops with two samples in flight.
    drive_cycle(1'b1, 4'b0011, 16'h0052, 4'b0010);
    drive_cycle(1'b1, 4'b0011, 16'h0052, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b0, 4'b1111, 16'h1111, 4'b0000);
      chk("t5_busy", 32'(busy), 32'(exp5[k]));
    end
    idle(1);
    chk("t5_sb_drained", 32'(sb.size()), 32'd0);

    // Reset in the cycle after a transfer.
    drive_cycle(1'b1, 4'b0000, 16'h0000, 4'b0000);
    drive_cycle(1'b1, 4'b0001, 16'h0003, 4'b0001);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("t6_flt_in_valid", 32'(flt_in_valid), 32'd0);
    chk("t6_flt_in_data", 32'(flt_in_data), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_req_ready", 32'(bus.req_ready), 32'd0);
    chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    en            = 1'b0;
    bus.req_valid = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t6_no_rsp_after_rst", 32'(bus.rsp_valid), 32'd0);
    end

    chk("final_sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
